avmm_hex_display: RTL and testbench

//  Avalon-MM responder that drives the eight DE2 seven-segment displays directly from Nios II writes.
//  - Replaces eight separate PIO cores with one memory-mapped slave.
//  - Holds digit nibbles plus blank/DP/blink masks, decodes each nibble to active-low segments, and registers the outputs.
//  - Sits in the Qsys system; its conduit outputs go to HEX0..HEX7 in the top level.

---
 rtl/hex_disp_pkg.sv | 22 ++
 rtl/hex_seg_decoder.sv | 13 +
 rtl/avmm_hex_display.sv | 169 ++++++++++++++++
 tb/tb_avmm_hex_display.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared constants for the Avalon-MM seven-segment display block: register map,
// reset values and the active-low segment table (bit order g..a).
// Pure declarations; no logic, no latency, no flow control.
package hex_disp_pkg;

   localparam logic [1:0] ADDR_DIGITS = 2'd0;
   localparam logic [1:0] ADDR_BLANK  = 2'd1;
   localparam logic [1:0] ADDR_DP     = 2'd2;
   localparam logic [1:0] ADDR_BLINK  = 2'd3;

   localparam logic [31:0] RST_DIGITS = 32'h0000_0000;
   localparam logic [7:0]  RST_BLANK  = 8'hFF;
   localparam logic [7:0]  RST_DP     = 8'h00;
   localparam logic [7:0]  RST_BLINK  = 8'h00;

   // Index 0 sits at the LSB end, so the list reads F down to 0.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/hex_seg_decoder.sv
// Purpose: nibble to active-low seven-segment pattern ([6:0] = g..a).
// Latency: combinational.
// Backpressure: none.
module hex_seg_decoder
   import hex_disp_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/avmm_hex_display.sv
// Purpose: Avalon-MM slave driving eight seven-segment digits (digits, blank, DP, blink masks).
// Latency: readdata 1 cycle after avs_read; hexN shows a write one edge after the register updates.
// Backpressure: none, every access accepted the cycle it is presented. Blink enabled by HEX_BLINK_EN.
module avmm_hex_display
   import hex_disp_pkg::*;
#(
   parameter int unsigned BLINK_DIV = 25_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  avs_address,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic [3:0]  avs_byteenable,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   output logic [7:0]  hex0,
   output logic [7:0]  hex1,
   output logic [7:0]  hex2,
   output logic [7:0]  hex3,
   output logic [7:0]  hex4,
   output logic [7:0]  hex5,
   output logic [7:0]  hex6,
   output logic [7:0]  hex7
);

   logic [31:0]     digits_q, digits_d;
   logic [7:0]      blank_q, blank_d;
   logic [7:0]      dp_q, dp_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [7:0][7:0] hex_q, hex_d;
   logic [7:0][6:0] seg;
   logic [7:0]      blink_mask;
   logic            phase;
   logic [31:0]     rd_mux;

   // Merge write data into a register, one byte lane at a time.
   function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

`ifdef HEX_BLINK_EN
   localparam int unsigned CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

   logic [7:0]    blink_q, blink_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;

   // Free-running prescaler; phase flips each time the counter wraps.
   always_comb begin
      cnt_d   = cnt_q + CW'(1);
      phase_d = phase_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

   // BLINK mask register: only byte lane 0 carries live bits.
   always_comb begin
      blink_d = blink_q;
      if (avs_write && avs_address == ADDR_BLINK && avs_byteenable[0])
         blink_d = avs_writedata[7:0];
   end

   // Prescaler and blink mask state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
         blink_q <= RST_BLINK;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         blink_q <= blink_d;
      end
   end

   assign blink_mask = blink_q;
   assign phase      = phase_q;
`else
   assign blink_mask = 8'h00;
   assign phase      = 1'b0;
`endif

   // Read mux over the current (pre-write) register contents; unused bits read 0.
   always_comb begin
      rd_mux = 32'h0;
      case (avs_address)
         ADDR_DIGITS: rd_mux = digits_q;
         ADDR_BLANK:  rd_mux = {24'h0, blank_q};
         ADDR_DP:     rd_mux = {24'h0, dp_q};
`ifdef HEX_BLINK_EN
         ADDR_BLINK:  rd_mux = {24'h0, blink_mask};
`endif
         default:     rd_mux = 32'h0;
      endcase
   end

   // Bus-side register updates and registered read data.
   always_comb begin
      digits_d = digits_q;
      blank_d  = blank_q;
      dp_d     = dp_q;
      rdata_d  = rdata_q;
      if (avs_read) rdata_d = rd_mux;
      if (avs_write) begin
         case (avs_address)
            ADDR_DIGITS: digits_d = merge_be(digits_q, avs_writedata, avs_byteenable);
            ADDR_BLANK:  if (avs_byteenable[0]) blank_d = avs_writedata[7:0];
            ADDR_DP:     if (avs_byteenable[0]) dp_d = avs_writedata[7:0];
            default:     ;
         endcase
      end
   end

   // One decoder per digit.
   for (genvar i = 0; i < 8; i++) begin : g_dec
      hex_seg_decoder u_dec (
         .nib (digits_q[4*i +: 4]),
         .seg (seg[i])
      );
   end

   // Per-digit output value: blanked (or blinked off) digits go fully dark.
   always_comb begin
      hex_d = '1;
      for (int i = 0; i < 8; i++) begin
         if (blank_q[i] || (blink_mask[i] && phase)) hex_d[i] = 8'hFF;
         else                                        hex_d[i] = {~dp_q[i], seg[i]};
      end
   end

   // Register file, read data and output flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digits_q <= RST_DIGITS;
         blank_q  <= RST_BLANK;
         dp_q     <= RST_DP;
         rdata_q  <= 32'h0;
         hex_q    <= '1;
      end else begin
         digits_q <= digits_d;
         blank_q  <= blank_d;
         dp_q     <= dp_d;
         rdata_q  <= rdata_d;
         hex_q    <= hex_d;
      end
   end

   assign avs_readdata = rdata_q;
   assign hex0 = hex_q[0];
   assign hex1 = hex_q[1];
   assign hex2 = hex_q[2];
   assign hex3 = hex_q[3];
   assign hex4 = hex_q[4];
   assign hex5 = hex_q[5];
   assign hex6 = hex_q[6];
   assign hex7 = hex_q[7];

endmodule

// File: tb/tb_avmm_hex_display.sv
// Directed bench for avmm_hex_display with BLINK_DIV=4; blink expectations follow HEX_BLINK_EN.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_avmm_hex_display;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  avs_address = 2'd0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = 32'h0;
   logic [3:0]  avs_byteenable = 4'h0;
   logic        avs_read = 1'b0;
   logic [31:0] avs_readdata;
   logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
   logic [7:0]  hx [8];

   int checks = 0;
   int errors = 0;

   avmm_hex_display #(.BLINK_DIV(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .avs_address    (avs_address),
      .avs_write      (avs_write),
      .avs_writedata  (avs_writedata),
      .avs_byteenable (avs_byteenable),
      .avs_read       (avs_read),
      .avs_readdata   (avs_readdata),
      .hex0           (hex0),
      .hex1           (hex1),
      .hex2           (hex2),
      .hex3           (hex3),
      .hex4           (hex4),
      .hex5           (hex5),
      .hex6           (hex6),
      .hex7           (hex7)
   );

   always #5 clk = ~clk;

   assign hx[0] = hex0;
   assign hx[1] = hex1;
   assign hx[2] = hex2;
   assign hx[3] = hex3;
   assign hx[4] = hex4;
   assign hx[5] = hex5;
   assign hx[6] = hex6;
   assign hx[7] = hex7;

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      avs_address    = a;
      avs_writedata  = d;
      avs_byteenable = be;
      avs_write      = 1'b1;
      @(negedge clk);
      avs_write      = 1'b0;
      avs_byteenable = 4'h0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      avs_address = a;
      avs_read    = 1'b1;
      @(negedge clk);
      avs_read = 1'b0;
      d = avs_readdata;
   endtask

   task automatic test_reset;
      logic [31:0] rd;
      // Dirty some state first so reset has something to clear.
      bus_write(2'd0, 32'h1234_5678, 4'hF);
      bus_write(2'd1, 32'h0000_0000, 4'hF);
      bus_write(2'd2, 32'h0000_00FF, 4'hF);
      bus_read(2'd0, rd);
      #2 reset = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (hx[i] !== 8'hFF) begin
            errors++;
            $display("FAIL reset_hex%0d: got %h expected ff", i, hx[i]);
         end
      end
      checks++;
      if (avs_readdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_readdata: got %h expected 00000000", avs_readdata);
      end
      @(negedge clk);
      reset = 1'b0;
      bus_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0000_00FF) begin
         errors++;
         $display("FAIL reset_blank: got %h expected 000000ff", rd);
      end
      bus_read(2'd0, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL reset_digits: got %h expected 00000000", rd);
      end
      bus_read(2'd2, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL reset_dp: got %h expected 00000000", rd);
      end
   endtask

   task automatic test_digits;
      logic [7:0] exp_hex [8];
      exp_hex = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
      bus_write(2'd0, 32'h7654_3210, 4'hF);
      @(negedge clk);
      checks++;
      if (hex3 !== 8'hFF) begin
         errors++;
         $display("FAIL digits_still_blank: got %h expected ff", hex3);
      end
      bus_write(2'd1, 32'h0, 4'hF);
      // One edge after the write only the register has moved.
      checks++;
      if (hex0 !== 8'hFF) begin
         errors++;
         $display("FAIL digits_latency: got %h expected ff", hex0);
      end
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (hx[i] !== exp_hex[i]) begin
            errors++;
            $display("FAIL digits_hex%0d: got %h expected %h", i, hx[i], exp_hex[i]);
         end
      end
   endtask

   task automatic test_byteenable;
      logic [31:0] rd;
      logic [7:0]  exp_hex [8];
      exp_hex = '{8'hC0, 8'hF9, 8'h83, 8'h88, 8'h99, 8'h92, 8'h82, 8'hF8};
      bus_write(2'd0, 32'h0000_AB00, 4'b0010);
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (hx[i] !== exp_hex[i]) begin
            errors++;
            $display("FAIL be_hex%0d: got %h expected %h", i, hx[i], exp_hex[i]);
         end
      end
      bus_read(2'd0, rd);
      checks++;
      if (rd !== 32'h7654_AB10) begin
         errors++;
         $display("FAIL be_readback: got %h expected 7654ab10", rd);
      end
   endtask

   task automatic test_masks;
      logic [31:0] rd;
      bus_write(2'd1, 32'h0000_0081, 4'hF);
      bus_write(2'd2, 32'hFFFF_FF02, 4'hF);
      @(negedge clk);
      checks++;
      if (hex0 !== 8'hFF) begin
         errors++;
         $display("FAIL mask_hex0: got %h expected ff", hex0);
      end
      checks++;
      if (hex7 !== 8'hFF) begin
         errors++;
         $display("FAIL mask_hex7: got %h expected ff", hex7);
      end
      checks++;
      if (hex1 !== 8'h79) begin
         errors++;
         $display("FAIL mask_hex1_dp: got %h expected 79", hex1);
      end
      checks++;
      if (hex2 !== 8'h83) begin
         errors++;
         $display("FAIL mask_hex2: got %h expected 83", hex2);
      end
      bus_read(2'd2, rd);
      checks++;
      if (rd !== 32'h0000_0002) begin
         errors++;
         $display("FAIL mask_dp_read: got %h expected 00000002", rd);
      end
   endtask

   task automatic test_simul_rw;
      logic [31:0] rd;
      @(negedge clk);
      avs_address    = 2'd2;
      avs_writedata  = 32'h0000_00FF;
      avs_byteenable = 4'hF;
      avs_write      = 1'b1;
      avs_read       = 1'b1;
      @(negedge clk);
      avs_write      = 1'b0;
      avs_read       = 1'b0;
      avs_byteenable = 4'h0;
      checks++;
      if (avs_readdata !== 32'h0000_0002) begin
         errors++;
         $display("FAIL rw_prewrite: got %h expected 00000002", avs_readdata);
      end
      bus_read(2'd2, rd);
      checks++;
      if (rd !== 32'h0000_00FF) begin
         errors++;
         $display("FAIL rw_postwrite: got %h expected 000000ff", rd);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (avs_readdata !== 32'h0000_00FF) begin
         errors++;
         $display("FAIL rw_hold: got %h expected 000000ff", avs_readdata);
      end
   endtask

   task automatic test_blink;
      logic [31:0] rd;
      logic [7:0]  prev;
      logic [7:0]  expv;
      bit          found;
      bus_write(2'd1, 32'h0, 4'hF);
      bus_write(2'd2, 32'h0, 4'hF);
      bus_write(2'd3, 32'hFFFF_FF01, 4'hF);
      @(negedge clk);
`ifdef HEX_BLINK_EN
      prev  = hex0;
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge clk);
         if (hex0 !== prev) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL blink_toggle: hex0 stuck at %h, expected a toggle within 20 cycles", hex0);
      end else begin
         expv = hex0;
         checks++;
         if (expv !== 8'hFF && expv !== 8'hC0) begin
            errors++;
            $display("FAIL blink_value: got %h expected ff or c0", expv);
         end
         for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 4; j++) begin
               checks++;
               if (hex0 !== expv) begin
                  errors++;
                  $display("FAIL blink_p%0d_c%0d: got %h expected %h", p, j, hex0, expv);
               end
               checks++;
               if (hex1 !== 8'hF9) begin
                  errors++;
                  $display("FAIL blink_hex1_steady: got %h expected f9", hex1);
               end
               @(negedge clk);
            end
            expv = (expv == 8'hFF) ? 8'hC0 : 8'hFF;
         end
      end
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0000_0001) begin
         errors++;
         $display("FAIL blink_read: got %h expected 00000001", rd);
      end
`else
      for (int n = 0; n < 12; n++) begin
         checks++;
         if (hex0 !== 8'hC0) begin
            errors++;
            $display("FAIL noblink_hex0_c%0d: got %h expected c0", n, hex0);
         end
         @(negedge clk);
      end
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL noblink_read: got %h expected 00000000", rd);
      end
`endif
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_digits();
      test_byteenable();
      test_masks();
      test_simul_rw();
      test_blink();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
